// File: rtl/qam_stream_mapper.sv
// Byte stream to Gray-coded BPSK/QPSK/16QAM/64QAM I/Q symbol mapper.
// Valid/ready on both sides, per-frame mode lock, zero padding of the final symbol.
module qam_stream_mapper #(
  parameter int unsigned W   = 8,
  parameter int unsigned AMP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [2*W-1:0]   m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy
);

  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 5;
  localparam int          AMP_S = int'(AMP);

  if (7 * AMP > (2 ** (W - 1)) - 1) begin : g_amp_check
    $error("qam_stream_mapper: 7*AMP does not fit signed W");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             pend_last_q, pend_last_d;
  logic             busy_q, busy_d;
  logic [2*W-1:0]   m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;

  logic [CNT_W-1:0] bps, used, cnt_rem;
  logic             accept, emit, is_last;
  logic [5:0]       sym;
  logic signed [3:0] lvl_i, lvl_q;
  logic [W-1:0]     i_val, q_val;
  logic [ACC_W-1:0] acc_shift;

  // 64QAM Gray triple to level: 000 -7 ... 100 +7
  function automatic logic signed [3:0] lvl64(input logic [2:0] b);
    case (b)
      3'b000:  lvl64 = -4'sd7;
      3'b001:  lvl64 = -4'sd5;
      3'b011:  lvl64 = -4'sd3;
      3'b010:  lvl64 = -4'sd1;
      3'b110:  lvl64 = 4'sd1;
      3'b111:  lvl64 = 4'sd3;
      3'b101:  lvl64 = 4'sd5;
      default: lvl64 = 4'sd7;
    endcase
  endfunction

  always_comb begin
    bps       = CNT_W'(1);
    lvl_i     = 4'sd0;
    lvl_q     = 4'sd0;
    acc_d     = acc_q;
    count_d   = count_q;
    mode_d    = mode_q;
    pend_last_d = pend_last_q;
    busy_d    = busy_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    case (mode_q)
      2'd0:    bps = CNT_W'(1);
      2'd1:    bps = CNT_W'(2);
      2'd2:    bps = CNT_W'(4);
      default: bps = CNT_W'(6);
    endcase

    s_ready = (count_q <= CNT_W'(8)) && !pend_last_q;
    accept  = s_valid && s_ready;
    emit    = ((count_q >= bps) || (pend_last_q && (count_q != '0))) && (!m_valid_q || m_ready);
    used    = emit ? ((count_q < bps) ? count_q : bps) : '0;
    is_last = emit && pend_last_q && (count_q <= bps);
    cnt_rem = count_q - used;
    acc_shift = acc_q << used;
    sym     = acc_q[ACC_W-1 -: 6];

    // Bits below the valid count are always zero, so padding is implicit
    case (mode_q)
      2'd0: lvl_i = sym[5] ? 4'sd1 : -4'sd1;
      2'd1: begin
        lvl_i = sym[5] ? 4'sd1 : -4'sd1;
        lvl_q = sym[4] ? -4'sd1 : 4'sd1;
      end
      2'd2: begin
        case (sym[5:4])
          2'b00:   lvl_i = -4'sd3;
          2'b01:   lvl_i = -4'sd1;
          2'b11:   lvl_i = 4'sd1;
          default: lvl_i = 4'sd3;
        endcase
        case (sym[3:2])
          2'b00:   lvl_q = 4'sd3;
          2'b01:   lvl_q = 4'sd1;
          2'b11:   lvl_q = -4'sd1;
          default: lvl_q = -4'sd3;
        endcase
      end
      default: begin
        lvl_i = lvl64(sym[5:3]);
        lvl_q = -lvl64(sym[2:0]);
      end
    endcase
    i_val = W'(int'(lvl_i) * AMP_S);
    q_val = W'(int'(lvl_q) * AMP_S);

    acc_d   = acc_shift;
    count_d = cnt_rem;
    if (accept) begin
      acc_d       = acc_shift | ({s_data, 8'h00} >> cnt_rem);
      count_d     = cnt_rem + CNT_W'(8);
      pend_last_d = s_last;
      if (!busy_q) begin
        mode_d = cfg_mode;
        busy_d = 1'b1;
      end
    end
    if (is_last) begin
      pend_last_d = 1'b0;
      busy_d      = 1'b0;
    end

    if (emit) begin
      m_data_d  = {q_val, i_val};
      m_valid_d = 1'b1;
      m_last_d  = is_last;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      pend_last_q <= 1'b0;
      busy_q      <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      pend_last_q <= pend_last_d;
      busy_q      <= busy_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_qam_stream_mapper.sv
// Randomised bench for qam_stream_mapper: AMP=1 and AMP=3 instances share stimulus,
// outputs are checked against a Gray-decode arithmetic model.
module tb_qam_stream_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, m_last, busy;
  logic [15:0] m_data;
  logic        s_ready3, m_valid3, m_last3, busy3;
  logic [15:0] m_data3;

  int total = 0;
  int bad = 0;
  logic [7:0] frame_bytes[$];

  always #5 clk = ~clk;

  qam_stream_mapper #(.W(8), .AMP(1)) u_dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy));

  qam_stream_mapper #(.W(8), .AMP(3)) u_amp3 (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready3), .m_data(m_data3), .m_valid(m_valid3),
    .m_last(m_last3), .m_ready(m_ready), .busy(busy3));

  function automatic int gray2bin(input int g);
    return g ^ (g >> 1) ^ (g >> 2);
  endfunction

  // Symbol bits are left-aligned in s; level = 2*index - (M-1), Q axis negated
  function automatic logic [15:0] ref_sym(input logic [5:0] s, input logic [1:0] mode, input int amp);
    int k, m, gi, gq, li, lq;
    logic [7:0] iv, qv;
    if (mode == 2'd0) begin
      li = s[5] ? 1 : -1;
      lq = 0;
    end else begin
      k  = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 3;
      m  = (1 << k) - 1;
      gi = (int'(s) >> (6 - k)) & m;
      gq = (int'(s) >> (6 - 2 * k)) & m;
      li = 2 * gray2bin(gi) - m;
      lq = -(2 * gray2bin(gq) - m);
    end
    iv = 8'(li * amp);
    qv = 8'(lq * amp);
    return {qv, iv};
  endfunction

  task automatic run_frame(input logic [1:0] mode, input int alt_mode, input int rdy_mode,
                           input bit vrand, input string name);
    logic [5:0] exp_q[$];
    bit bits[$];
    logic [5:0] sy;
    logic [15:0] held_d, want;
    logic held_l, exp_busy;
    int bps, n, nbytes, byte_idx, out_idx, t, acc_t, first_v;
    bit stall;
    bps = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 6;
    nbytes = frame_bytes.size();
    foreach (frame_bytes[i])
      for (int b = 7; b >= 0; b--) bits.push_back(frame_bytes[i][b]);
    while (bits.size() > 0) begin
      sy = '0;
      for (int j = 0; j < bps; j++) sy[5-j] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
      exp_q.push_back(sy);
    end
    n = exp_q.size();
    byte_idx = 0; out_idx = 0; t = 0; acc_t = -1; first_v = -1; stall = 0;
    held_d = '0; held_l = 1'b0;
    cfg_mode = mode;
    while (out_idx < n && t < 2000) begin
      if (byte_idx < nbytes) begin
        s_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data  = frame_bytes[byte_idx];
        s_last  = (byte_idx == nbytes - 1);
      end else begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
      end
      if (alt_mode >= 0 && byte_idx >= 1) cfg_mode = 2'(alt_mode);
      m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((t % 2) == 1) : 1'($urandom_range(0, 1));

      if (stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
          bad++;
          $display("FAIL %s stall_hold t=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   name, t, m_valid, m_data, m_last, held_d, held_l);
        end
      end
      exp_busy = (byte_idx > 0) && !(m_valid && m_last);
      total++;
      if (busy !== exp_busy || busy3 !== exp_busy) begin
        bad++;
        $display("FAIL %s busy t=%0d: got %b/%b want %b", name, t, busy, busy3, exp_busy);
      end
      if (byte_idx == nbytes) begin
        total++;
        if (s_ready !== (m_valid && m_last)) begin
          bad++;
          $display("FAIL %s s_ready_after_last t=%0d: got %b want %b", name, t, s_ready, m_valid && m_last);
        end
      end
      if (m_valid && first_v < 0) begin
        first_v = t;
        total++;
        if (first_v - acc_t != 2) begin
          bad++;
          $display("FAIL %s latency: got %0d want 2", name, first_v - acc_t);
        end
      end
      if (m_valid && m_ready) begin
        want = ref_sym(exp_q[out_idx], mode, 1);
        total++;
        if (m_data !== want || m_last !== (out_idx == n - 1)) begin
          bad++;
          $display("FAIL %s sym%0d: got d=%h l=%b want d=%h l=%b",
                   name, out_idx, m_data, m_last, want, out_idx == n - 1);
        end
        want = ref_sym(exp_q[out_idx], mode, 3);
        total++;
        if (m_valid3 !== 1'b1 || m_data3 !== want || m_last3 !== (out_idx == n - 1)) begin
          bad++;
          $display("FAIL %s amp3_sym%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   name, out_idx, m_valid3, m_data3, m_last3, want, out_idx == n - 1);
        end
        out_idx++;
      end
      stall  = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (s_valid && s_ready) begin
        if (acc_t < 0) acc_t = t;
        byte_idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    if (out_idx < n) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d symbols want %0d", name, out_idx, n);
    end
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || m_data !== 16'h0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got v=%b l=%b b=%b d=%h r=%b want 0 0 0 0000 1",
               m_valid, m_last, busy, m_data, s_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    cfg_mode = 2'd2; s_data = 8'h00; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    k = 0;
    while (!m_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_prep: got v=%b busy=%b want 1 1", m_valid, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_frame: got v=%b l=%b b=%b want 0 0 0", m_valid, m_last, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got r=%b v=%b d=%h b=%b want 1 0 0000 0", s_ready, m_valid, m_data, busy);
    end
  endtask

  task automatic test_16qam();
    frame_bytes = '{8'h5A};
    run_frame(2'd2, -1, 0, 1'b0, "qam16_5a");
    frame_bytes = '{8'h00, 8'hC3};
    run_frame(2'd2, -1, 0, 1'b0, "qam16_legacy");
  endtask

  task automatic test_bpsk();
    frame_bytes = '{8'hA5};
    run_frame(2'd0, -1, 0, 1'b0, "bpsk_a5");
  endtask

  task automatic test_64qam_pad();
    frame_bytes = '{8'hFF};
    run_frame(2'd3, -1, 0, 1'b0, "qam64_pad");
    frame_bytes = '{8'h1B, 8'h7E, 8'h42};
    run_frame(2'd3, -1, 2, 1'b0, "qam64_exact");
  endtask

  task automatic test_back_to_back();
    frame_bytes = {};
    for (int i = 0; i < 4; i++) frame_bytes.push_back(8'($urandom));
    run_frame(2'd1, -1, 1, 1'b0, "qpsk_b2b");
  endtask

  task automatic test_mode_lock();
    frame_bytes = '{8'h3C, 8'h96};
    run_frame(2'd2, 0, 0, 1'b0, "mode_lock");
    frame_bytes = '{8'h69};
    run_frame(2'd0, -1, 0, 1'b0, "mode_next_bpsk");
  endtask

  task automatic test_random();
    int nb;
    for (int f = 0; f < 24; f++) begin
      nb = $urandom_range(1, 6);
      frame_bytes = {};
      for (int i = 0; i < nb; i++) frame_bytes.push_back(8'($urandom));
      run_frame(2'($urandom_range(0, 3)), -1, 2, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_16qam();
    test_bpsk();
    test_64qam_pad();
    test_back_to_back();
    test_mode_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
